move_input: RTL and testbench

MOVE_INPUT -- requirements
Module: move_input

---
 rtl/move_input.sv | 143 ++++++++++++++
 tb/tb_move_input.sv | 125 ++++++++++++
 2 files changed

// File: rtl/move_input.sv
// Push-button front end: synchronize, debounce, auto-repeat and arbitrate four
// direction buttons into one-cycle, mutually exclusive move pulses.
module move_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned REPEAT_DELAY    = 12500000,
   parameter int unsigned REPEAT_RATE     = 5000000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SW1,
   input  logic       SW2,
   input  logic       SW3,
   input  logic       SW4,
   input  logic       enable,
   output logic       move_up,
   output logic       move_down,
   output logic       move_left,
   output logic       move_right,
   output logic [3:0] btn_state
);

   localparam int unsigned MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int unsigned MAX_P = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
   localparam int unsigned CW    = $clog2(MAX_P) + 1;

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

   logic [3:0]    sw_raw, sync1, sync2, deb, deb_q;
   logic [CW-1:0] deb_cnt [4];
   logic [CW-1:0] rep_cnt [4];
   logic [CW-1:0] rep_cnt_nxt [4];
   rep_state_t    state [4];
   rep_state_t    state_nxt [4];
   logic [3:0]    press_req, rep_req, req, pending, pending_nxt, issue;

   assign sw_raw    = {SW4, SW3, SW2, SW1};
   assign btn_state = deb;
   assign press_req = deb & ~deb_q;
   assign req       = press_req | rep_req;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int unsigned i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
         deb_q <= deb;
         for (int unsigned i = 0; i < 4; i++) begin
            if (sync2[i] != deb[i]) begin
               if (deb_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                  deb[i]     <= sync2[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + CW'(1);
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 0; i < 4; i++) begin
            state[i]   <= IDLE;
            rep_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            state[i]   <= state_nxt[i];
            rep_cnt[i] <= rep_cnt_nxt[i];
         end
      end
   end

   // A low debounced level wins over a counter expiry on the same edge.
   always_comb begin
      rep_req = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         state_nxt[i]   = state[i];
         rep_cnt_nxt[i] = rep_cnt[i] + CW'(1);
         if (!deb[i]) begin
            state_nxt[i]   = IDLE;
            rep_cnt_nxt[i] = '0;
         end else begin
            unique case (state[i])
               IDLE: begin
                  rep_cnt_nxt[i] = '0;
                  if (press_req[i]) state_nxt[i] = DELAY;
               end
               DELAY: begin
                  if (rep_cnt[i] == CW'(REPEAT_DELAY - 1)) begin
                     state_nxt[i]   = REPEAT;
                     rep_req[i]     = 1'b1;
                     rep_cnt_nxt[i] = '0;
                  end
               end
               REPEAT: begin
                  if (rep_cnt[i] == CW'(REPEAT_RATE - 1)) begin
                     rep_req[i]     = 1'b1;
                     rep_cnt_nxt[i] = '0;
                  end
               end
               default: begin
                  state_nxt[i]   = IDLE;
                  rep_cnt_nxt[i] = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      issue = '0;
      if (pending[0])      issue = 4'b0001;
      else if (pending[1]) issue = 4'b0010;
      else if (pending[2]) issue = 4'b0100;
      else if (pending[3]) issue = 4'b1000;
      pending_nxt = enable ? ((pending & ~issue) | req) : '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pending    <= '0;
         move_up    <= 1'b0;
         move_down  <= 1'b0;
         move_left  <= 1'b0;
         move_right <= 1'b0;
      end else begin
         pending    <= pending_nxt;
         move_up    <= enable & issue[0];
         move_down  <= enable & issue[1];
         move_left  <= enable & issue[2];
         move_right <= enable & issue[3];
      end
   end

endmodule

// File: tb/tb_move_input.sv
// Directed bench for move_input with short debounce/repeat timings; time
// indices k count clock edges from the first edge that samples a button high.
module tb_move_input;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       SW1 = 1'b0, SW2 = 1'b0, SW3 = 1'b0, SW4 = 1'b0;
   logic       enable = 1'b1;
   logic       move_up, move_down, move_left, move_right;
   logic [3:0] btn_state;
   logic [3:0] mv;
   logic [3:0] exp_mv, exp_btn;

   int checks = 0;
   int fails  = 0;

   move_input #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_RATE    (5)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .SW1       (SW1),
      .SW2       (SW2),
      .SW3       (SW3),
      .SW4       (SW4),
      .enable    (enable),
      .move_up   (move_up),
      .move_down (move_down),
      .move_left (move_left),
      .move_right(move_right),
      .btn_state (btn_state)
   );

   always #5 CLK = ~CLK;

   assign mv = {move_right, move_left, move_down, move_up};

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s t%0d observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   initial begin
      // reset
      RST = 1'b1;
      repeat (3) tick;
      check("rst_move", 0, mv, 4'b0000);
      check("rst_btn", 0, btn_state, 4'b0000);
      RST = 1'b0;
      repeat (3) tick;

      // glitch shorter than the debounce window
      SW1 = 1'b1;
      for (int k = 0; k <= 15; k++) begin
         tick;
         check("glitch_move", k, mv, 4'b0000);
         check("glitch_btn", k, btn_state, 4'b0000);
         if (k == 2) SW1 = 1'b0;
      end

      // held button: press, delay, auto-repeat, release
      SW1 = 1'b1;
      for (int k = 0; k <= 55; k++) begin
         tick;
         exp_mv  = (k inside {7, 17, 22, 27, 32, 37, 42}) ? 4'b0001 : 4'b0000;
         exp_btn = (k >= 5 && k <= 44) ? 4'b0001 : 4'b0000;
         check("hold_move", k, mv, exp_mv);
         check("hold_btn", k, btn_state, exp_btn);
         if (k == 39) SW1 = 1'b0;
      end

      // simultaneous up + right: priority serialises them
      SW1 = 1'b1;
      SW4 = 1'b1;
      for (int k = 0; k <= 25; k++) begin
         tick;
         exp_mv = (k == 7) ? 4'b0001 : (k == 8) ? 4'b1000 : 4'b0000;
         check("prio_move", k, mv, exp_mv);
         if (k == 7) begin
            SW1 = 1'b0;
            SW4 = 1'b0;
         end
      end

      // enable low swallows the press pulse; repeats continue afterwards
      SW2 = 1'b1;
      for (int k = 0; k <= 50; k++) begin
         tick;
         exp_mv  = (k inside {17, 22, 27, 32, 37}) ? 4'b0010 : 4'b0000;
         exp_btn = (k >= 5 && k <= 39) ? 4'b0010 : 4'b0000;
         check("en_move", k, mv, exp_mv);
         check("en_btn", k, btn_state, exp_btn);
         if (k == 5)  enable = 1'b0;
         if (k == 12) enable = 1'b1;
         if (k == 34) SW2 = 1'b0;
      end

      // reset while held: treated as a fresh press afterwards
      SW3 = 1'b1;
      for (int k = 0; k <= 45; k++) begin
         tick;
         exp_mv  = (k inside {7, 17, 28}) ? 4'b0100 : 4'b0000;
         exp_btn = ((k >= 5 && k <= 19) || (k >= 26 && k <= 35)) ? 4'b0100 : 4'b0000;
         check("rst_held_move", k, mv, exp_mv);
         check("rst_held_btn", k, btn_state, exp_btn);
         if (k == 19) RST = 1'b1;
         if (k == 20) RST = 1'b0;
         if (k == 30) SW3 = 1'b0;
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
